// File: rtl/dsi_b2p_gearbox.sv
// DSI byte-to-pixel gearbox: long-packet payload beats -> byte FIFO -> one 24-bit pixel per clock,
// plus VSS/HSS pulse generation. RGB565 decode is built only when DSI_RGB565_EN is defined.
module dsi_b2p_gearbox #(
  parameter int NUM_LANES  = 4,
  parameter int FIFO_DEPTH = 256,
  parameter int VS_WIDTH   = 2,
  parameter int HS_WIDTH   = 2
) (
  input  logic                        clk_byte_i,
  input  logic                        reset_byte_n_i,
  input  logic [8*NUM_LANES-1:0]      payload_i,
  input  logic                        payload_en_i,
  input  logic                        lp_av_en_i,
  input  logic                        sp_en_i,
  input  logic [5:0]                  dt_i,
  input  logic [15:0]                 wc_i,
  input  logic                        clr_err_i,
  output logic [23:0]                 pd_o,
  output logic                        de_o,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        ovf_o,
  output logic                        fmt_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int VW = $clog2(VS_WIDTH + 1);
  localparam int HW = $clog2(HS_WIDTH + 1);
  localparam logic [5:0] DT_RGB888 = 6'h3E;
  localparam logic [5:0] DT_VSS    = 6'h01;
  localparam logic [5:0] DT_HSS    = 6'h21;
`ifdef DSI_RGB565_EN
  localparam logic [5:0] DT_RGB565 = 6'h0E;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_DROP} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_rem;
  logic            r_first_pend;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [VW-1:0]   r_vs_cnt;
  logic [HW-1:0]   r_hs_cnt;
  logic [7:0]      r_mem_data  [FIFO_DEPTH];
  logic            r_mem_first [FIFO_DEPTH];
  logic            r_mem_last  [FIFO_DEPTH];
`ifdef DSI_RGB565_EN
  logic            r_pkt_565;
  logic            r_mem_565   [FIFO_DEPTH];
  logic [15:0]     w_rgb565;
`endif

  logic            w_hdr_ok, w_beat, w_pkt_beat, w_fits, w_wr_en, w_ovf_evt, w_last_beat;
  logic [2:0]      w_take, w_bpp, w_pop_n;
  logic            w_pix_vld, w_flush;
  logic [AW-1:0]   w_a1, w_a2;
  logic [23:0]     w_pix;

`ifdef DSI_RGB565_EN
  assign w_hdr_ok = (dt_i == DT_RGB888) || (dt_i == DT_RGB565);
`else
  assign w_hdr_ok = (dt_i == DT_RGB888);
`endif

  // Bytes this beat contributes: the lane count, or fewer on the packet's final beat.
  assign w_take      = (r_rem < 16'(NUM_LANES)) ? r_rem[2:0] : 3'(NUM_LANES);
  assign w_last_beat = (r_rem <= 16'(NUM_LANES));
  assign w_fits      = (LW'(w_take) <= (LW'(FIFO_DEPTH) - r_level));
  assign w_wr_en     = w_pkt_beat && (w_take != 3'd0) && w_fits;
  assign w_ovf_evt   = w_pkt_beat && !w_fits;

  always_ff @(posedge clk_byte_i or negedge reset_byte_n_i) begin
    if (!reset_byte_n_i) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt; // NOTE: non-blocking so every flop samples pre-edge values.
  end

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    w_state_nxt = r_state;
    if (lp_av_en_i) begin
      w_state_nxt = w_hdr_ok ? S_PKT : S_DROP;
    end else if (r_state != S_IDLE) begin
      if ((r_rem == 16'd0) || (payload_en_i && w_last_beat)) w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_beat     = 1'b0;
    w_pkt_beat = 1'b0;
    if (payload_en_i && !lp_av_en_i) begin
      w_beat     = (r_state != S_IDLE);
      w_pkt_beat = (r_state == S_PKT);
    end
  end

  always_ff @(posedge clk_byte_i or negedge reset_byte_n_i) begin
    if (!reset_byte_n_i) begin
      r_rem        <= '0;
      r_first_pend <= 1'b0;
`ifdef DSI_RGB565_EN
      r_pkt_565    <= 1'b0;
`endif
    end else if (lp_av_en_i) begin
      r_rem        <= wc_i;
      r_first_pend <= 1'b1;
`ifdef DSI_RGB565_EN
      r_pkt_565    <= (dt_i == DT_RGB565);
`endif
    end else begin
      if (w_beat)  r_rem        <= r_rem - 16'(w_take);
      if (w_wr_en) r_first_pend <= 1'b0;
    end
  end

  // NOTE: the storage array is not reset; only entries below the fill level are ever acted on.
  // Each byte carries packet-start/end marks so the reader can flush partial pixels.
  always_ff @(posedge clk_byte_i) begin
    if (w_wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (i < int'(w_take)) begin
          r_mem_data [r_wr_ptr + AW'(i)] <= payload_i[8*i +: 8];
          r_mem_first[r_wr_ptr + AW'(i)] <= (i == 0) && r_first_pend;
          r_mem_last [r_wr_ptr + AW'(i)] <= (i == int'(w_take) - 1) && w_last_beat;
`ifdef DSI_RGB565_EN
          r_mem_565  [r_wr_ptr + AW'(i)] <= r_pkt_565;
`endif
        end
      end
    end
  end

  always_comb begin
    w_a1      = r_rd_ptr + AW'(1);
    w_a2      = r_rd_ptr + AW'(2);
    w_bpp     = 3'd3;
    w_pix     = {r_mem_data[r_rd_ptr], r_mem_data[w_a1], r_mem_data[w_a2]};
`ifdef DSI_RGB565_EN
    w_rgb565  = {r_mem_data[w_a1], r_mem_data[r_rd_ptr]};
    if (r_mem_565[r_rd_ptr]) begin
      w_bpp = 3'd2;
      w_pix = {w_rgb565[15:11], w_rgb565[15:13], w_rgb565[10:5], w_rgb565[10:9],
               w_rgb565[4:0], w_rgb565[4:2]};
    end
`endif
    w_pop_n   = 3'd0;
    w_pix_vld = 1'b0;
    w_flush   = 1'b0;
    // A packet boundary inside the next pixel window means the head bytes are a partial pixel.
    if (r_level != '0) begin
      if (r_mem_last[r_rd_ptr] || ((r_level > LW'(1)) && r_mem_first[w_a1])) begin
        w_pop_n = 3'd1;
        w_flush = 1'b1;
      end else if ((w_bpp == 3'd3) && (r_level > LW'(1)) &&
                   (r_mem_last[w_a1] || ((r_level > LW'(2)) && r_mem_first[w_a2]))) begin
        w_pop_n = 3'd2;
        w_flush = 1'b1;
      end else if (r_level >= LW'(w_bpp)) begin
        w_pop_n   = w_bpp;
        w_pix_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_byte_i or negedge reset_byte_n_i) begin
    if (!reset_byte_n_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      pd_o      <= '0;
      de_o      <= 1'b0;
      ovf_o     <= 1'b0;
      fmt_err_o <= 1'b0;
      r_vs_cnt  <= '0;
      r_hs_cnt  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(w_take);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
      r_level  <= r_level + LW'(w_wr_en ? w_take : 3'd0) - LW'(w_pop_n);
      de_o     <= w_pix_vld;
      if (w_pix_vld) pd_o <= w_pix;

      if (w_ovf_evt)      ovf_o <= 1'b1;
      else if (clr_err_i) ovf_o <= 1'b0;
      if (w_flush)        fmt_err_o <= 1'b1;
      else if (clr_err_i) fmt_err_o <= 1'b0;

      if (sp_en_i && !lp_av_en_i && (dt_i == DT_VSS)) r_vs_cnt <= VW'(VS_WIDTH);
      else if (r_vs_cnt != '0)                        r_vs_cnt <= r_vs_cnt - VW'(1);
      if (sp_en_i && !lp_av_en_i && (dt_i == DT_HSS)) r_hs_cnt <= HW'(HS_WIDTH);
      else if (r_hs_cnt != '0)                        r_hs_cnt <= r_hs_cnt - HW'(1);
    end
  end

  assign vsync_o      = (r_vs_cnt != '0);
  assign hsync_o      = (r_hs_cnt != '0);
  assign fifo_level_o = r_level;

endmodule

// File: tb/tb_dsi_b2p_gearbox.sv
// Bench for dsi_b2p_gearbox: table of long packets with a pixel scoreboard, plus hand sequences
// for sync pulses, overflow (8-byte FIFO instance), error-clear priority, RGB565 and mid-packet reset.
module tb_dsi_b2p_gearbox;
  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8*NL-1:0] payload;
  logic            payload_en, lp_av_en, sp_en, clr_err, sel_s;
  logic [5:0]      dt;
  logic [15:0]     wc;

  logic [23:0] pd, pd_s;
  logic        de, hs, vs, ovf, fmt, de_s, hs_s, vs_s, ovf_s, fmt_s;
  logic [8:0]  lvl;
  logic [3:0]  lvl_s;

  always #5 clk = ~clk;

  dsi_b2p_gearbox #(.NUM_LANES(NL), .FIFO_DEPTH(256), .VS_WIDTH(2), .HS_WIDTH(2)) dut (
    .clk_byte_i(clk), .reset_byte_n_i(rst_n), .payload_i(payload),
    .payload_en_i(payload_en & ~sel_s), .lp_av_en_i(lp_av_en & ~sel_s), .sp_en_i(sp_en & ~sel_s),
    .dt_i(dt), .wc_i(wc), .clr_err_i(clr_err), .pd_o(pd), .de_o(de), .hsync_o(hs), .vsync_o(vs),
    .fifo_level_o(lvl), .ovf_o(ovf), .fmt_err_o(fmt));

  dsi_b2p_gearbox #(.NUM_LANES(NL), .FIFO_DEPTH(8), .VS_WIDTH(2), .HS_WIDTH(2)) dut_s (
    .clk_byte_i(clk), .reset_byte_n_i(rst_n), .payload_i(payload),
    .payload_en_i(payload_en & sel_s), .lp_av_en_i(lp_av_en & sel_s), .sp_en_i(sp_en & sel_s),
    .dt_i(dt), .wc_i(wc), .clr_err_i(clr_err), .pd_o(pd_s), .de_o(de_s), .hsync_o(hs_s), .vsync_o(vs_s),
    .fifo_level_o(lvl_s), .ovf_o(ovf_s), .fmt_err_o(fmt_s));

  typedef struct {
    logic [5:0] dt;
    int         wc;
    logic [7:0] seed;
    int         exp_pix;
    logic       exp_fmt;
  } vec_t;

  vec_t        vecs [7];
  logic [7:0]  pkt_bytes [0:63];
  logic [23:0] q [$];
  logic [23:0] q_s [$];
  int n_checks = 0, n_err = 0;
  int cyc = 0, beat0_cyc = 0, first_de_cyc = 0;
  int pix_cnt = 0, pix_cnt_s = 0;
  logic first_seen = 1'b0, mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every de_o must match the oldest expected pixel.
  always @(negedge clk) begin
    if (mon_en && de) begin
      pix_cnt++;
      if (!first_seen) begin
        first_seen   = 1'b1;
        first_de_cyc = cyc;
      end
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pixel_extra: got 0x%0h expected no pixel", pd);
      end else check("pixel", 32'(pd), 32'(q.pop_front()));
    end
    if (de_s) begin
      pix_cnt_s++;
      if (q_s.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pixel_s_extra: got 0x%0h expected no pixel", pd_s);
      end else check("pixel_s", 32'(pd_s), 32'(q_s.pop_front()));
    end
  end

  function automatic void push_888(input int n);
    for (int p = 0; p < n / 3; p++)
      q.push_back({pkt_bytes[3*p], pkt_bytes[3*p+1], pkt_bytes[3*p+2]});
  endfunction

  task automatic send_raw(input logic [5:0] t, input int n);
    @(posedge clk); #1;
    lp_av_en = 1'b1;
    dt       = t;
    wc       = 16'(n);
    for (int b = 0; b < (n + NL - 1) / NL; b++) begin
      @(posedge clk); #1;
      lp_av_en   = 1'b0;
      payload_en = 1'b1;
      for (int l = 0; l < NL; l++)
        payload[8*l +: 8] = (b*NL + l < n) ? pkt_bytes[b*NL + l] : 8'hEE;
      if (b == 0) beat0_cyc = cyc;
    end
    @(posedge clk); #1;
    lp_av_en   = 1'b0;
    payload_en = 1'b0;
    payload    = '0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (k < 200 && !(q.size() == 0 && lvl == '0 && !de)) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 200) begin
      n_err++;
      $display("FAIL %s_drain: got level %0d, %0d pixels pending, expected drained within 200 cycles",
               name, lvl, q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic sp_run(input logic [5:0] d0, input logic [5:0] d1, input int gap, input logic with_lp,
                        output int vs_n, output int hs_n, output int de_n, output logic vs1, output logic hs3);
    vs_n = 0; hs_n = 0; de_n = 0; vs1 = 1'b0; hs3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sp_en    = (i == 0) || (gap != 0 && i == gap);
      dt       = (i == 0) ? d0 : d1;
      lp_av_en = with_lp && (i == 0);
      wc       = '0;
      @(negedge clk);
      vs_n += int'(vs);
      hs_n += int'(hs);
      de_n += int'(de);
      if (i == 1) vs1 = vs;
      if (i == 3) hs3 = hs;
    end
    sp_en    = 1'b0;
    lp_av_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int vs_n, hs_n, de_n, pix_base, hi_n, exp565;
    logic vs1, hs3;

    vecs[0] = '{dt: 6'h3E, wc: 12, seed: 8'h01, exp_pix: 4, exp_fmt: 1'b0};
    vecs[1] = '{dt: 6'h3E, wc: 10, seed: 8'h01, exp_pix: 3, exp_fmt: 1'b1};
    vecs[2] = '{dt: 6'h3E, wc: 3,  seed: 8'hA0, exp_pix: 1, exp_fmt: 1'b0};
    vecs[3] = '{dt: 6'h3E, wc: 5,  seed: 8'h10, exp_pix: 1, exp_fmt: 1'b1};
    vecs[4] = '{dt: 6'h2A, wc: 6,  seed: 8'h30, exp_pix: 0, exp_fmt: 1'b0};
    vecs[5] = '{dt: 6'h3E, wc: 24, seed: 8'h40, exp_pix: 8, exp_fmt: 1'b0};
    vecs[6] = '{dt: 6'h3E, wc: 0,  seed: 8'h00, exp_pix: 0, exp_fmt: 1'b0};

    rst_n = 1'b0; payload = '0; payload_en = 1'b0; lp_av_en = 1'b0; sp_en = 1'b0;
    clr_err = 1'b0; sel_s = 1'b0; dt = '0; wc = '0;
    repeat (2) @(negedge clk);
    check("reset_pd", 32'(pd), 0);
    check("reset_flags", {de, hs, vs, ovf, fmt}, 0);
    check("reset_level", 32'(lvl), 0);
    check("reset_small", {lvl_s, de_s, hs_s, vs_s, ovf_s, fmt_s}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].wc; k++) pkt_bytes[k] = vecs[v].seed + 8'(k);
      if (vecs[v].dt == 6'h3E) push_888(vecs[v].wc);
      pix_base   = pix_cnt;
      first_seen = 1'b0;
      send_raw(vecs[v].dt, vecs[v].wc);
      wait_drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_npix", v), pix_cnt - pix_base, vecs[v].exp_pix);
      check($sformatf("vec%0d_fmt", v), 32'(fmt), 32'(vecs[v].exp_fmt));
      check($sformatf("vec%0d_level", v), 32'(lvl), 0);
      if (vecs[v].exp_pix > 0)
        check($sformatf("vec%0d_latency", v), first_de_cyc - beat0_cyc, 2);
      if (vecs[v].exp_fmt) begin
        pulse_clr();
        check($sformatf("vec%0d_fmt_clr", v), 32'(fmt), 0);
      end
    end

    sp_run(6'h01, 6'h21, 2, 1'b0, vs_n, hs_n, de_n, vs1, hs3);
    check("sp_vs_len", vs_n, 2);
    check("sp_hs_len", hs_n, 2);
    check("sp_no_de", de_n, 0);
    check("sp_vs_next_clk", 32'(vs1), 1);
    check("sp_hs_next_clk", 32'(hs3), 1);
    sp_run(6'h01, 6'h01, 1, 1'b0, vs_n, hs_n, de_n, vs1, hs3);
    check("sp_retrigger_vs", vs_n, 3);
    sp_run(6'h21, 6'h05, 3, 1'b0, vs_n, hs_n, de_n, vs1, hs3);
    check("sp_other_dt_vs", vs_n, 0);
    check("sp_other_dt_hs", hs_n, 2);
    sp_run(6'h01, 6'h01, 0, 1'b1, vs_n, hs_n, de_n, vs1, hs3);
    check("sp_lp_wins_vs", vs_n, 0);

    // Error event in the same cycle as a held clear: the flag must still rise for one cycle.
    pkt_bytes[0] = 8'h11; pkt_bytes[1] = 8'h22; pkt_bytes[2] = 8'h33; pkt_bytes[3] = 8'h44;
    push_888(4);
    @(posedge clk); #1 clr_err = 1'b1;
    send_raw(6'h3E, 4);
    hi_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hi_n += int'(fmt);
    end
    clr_err = 1'b0;
    check("clr_vs_event_fmt_pulse", hi_n, 1);
    check("clr_vs_event_queue", q.size(), 0);

    // Overflow on the 8-byte FIFO instance.
    sel_s = 1'b1;
    for (int k = 0; k < 12; k++) pkt_bytes[k] = 8'h01 + 8'(k);
    q_s.push_back(24'h010203);
    q_s.push_back(24'h040506);
    pix_base = pix_cnt;
    send_raw(6'h3E, 12);
    repeat (20) @(negedge clk);
    check("ovf_npix", pix_cnt_s, 2);
    check("ovf_flag", 32'(ovf_s), 1);
    check("ovf_level", 32'(lvl_s), 2);
    check("ovf_main_idle", pix_cnt - pix_base, 0);
    pulse_clr();
    check("ovf_clr", 32'(ovf_s), 0);
    sel_s = 1'b0;

    // RGB565 packet: converted only when the decoder is built.
    pkt_bytes[0] = 8'h00; pkt_bytes[1] = 8'hF8; pkt_bytes[2] = 8'hE0; pkt_bytes[3] = 8'h07;
`ifdef DSI_RGB565_EN
    q.push_back(24'hFF0000);
    q.push_back(24'h00FF00);
    exp565 = 2;
`else
    exp565 = 0;
`endif
    pix_base = pix_cnt;
    send_raw(6'h0E, 4);
    wait_drain("rgb565");
    check("rgb565_npix", pix_cnt - pix_base, exp565);
    check("rgb565_level", 32'(lvl), 0);
    check("rgb565_fmt", 32'(fmt), 0);

    // Reset asserted mid-packet with pixels in flight and vsync active.
    mon_en = 1'b0;
    for (int k = 0; k < 12; k++) pkt_bytes[k] = 8'h50 + 8'(k);
    @(posedge clk); #1 lp_av_en = 1'b1; dt = 6'h3E; wc = 16'd12;
    @(posedge clk); #1 lp_av_en = 1'b0; payload_en = 1'b1;
    payload = {pkt_bytes[3], pkt_bytes[2], pkt_bytes[1], pkt_bytes[0]};
    @(posedge clk); #1 sp_en = 1'b1; dt = 6'h01;
    payload = {pkt_bytes[7], pkt_bytes[6], pkt_bytes[5], pkt_bytes[4]};
    @(posedge clk); #1 sp_en = 1'b0; payload_en = 1'b0; payload = '0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("rst_mid_pd", 32'(pd), 0);
    check("rst_mid_flags", {de, hs, vs, ovf, fmt}, 0);
    check("rst_mid_level", 32'(lvl), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    q.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) pkt_bytes[k] = 8'h70 + 8'(k);
    push_888(6);
    pix_base = pix_cnt;
    first_seen = 1'b0;
    send_raw(6'h3E, 6);
    wait_drain("post_rst");
    check("post_rst_npix", pix_cnt - pix_base, 2);
    check("post_rst_latency", first_de_cyc - beat0_cyc, 2);
    check("post_rst_fmt", 32'(fmt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
